// File: rtl/fifo_access_if.sv
// Bundle of the requester, reader and FIFO-side signals around fifo_access_ctrl.
// The controller is the slave; requesters, reader and the FIFO together are the master side.
interface fifo_access_if #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int NUM_REQ    = 4
);
  localparam int OCC_W = $clog2(DEPTH) + 1;

  logic [NUM_REQ-1:0]            req;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            gnt;
  logic                          fifo_wr_en;
  logic [DATA_WIDTH-1:0]         fifo_data_in;
  logic                          fifo_full;
  logic                          fifo_empty;
  logic                          rd_req;
  logic                          rd_ack;
  logic                          fifo_rd_en;
  logic                          rd_valid;
  logic [OCC_W-1:0]              occupancy;

  modport master (
    output req, req_data, fifo_full, fifo_empty, rd_req,
    input  gnt, fifo_wr_en, fifo_data_in, rd_ack, fifo_rd_en, rd_valid, occupancy
  );

  modport slave (
    input  req, req_data, fifo_full, fifo_empty, rd_req,
    output gnt, fifo_wr_en, fifo_data_in, rd_ack, fifo_rd_en, rd_valid, occupancy
  );
endinterface

// File: rtl/fifo_access_ctrl.sv
// Shares one sync FIFO between NUM_REQ round-robin, burst-limited writers and a single reader,
// tracking committed occupancy itself so the FIFO's lagging flags never cause a bad transfer.
module fifo_access_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int NUM_REQ    = 4,
  parameter int MAX_BURST  = 4
) (
  input logic          clk,
  input logic          rst,
  fifo_access_if.slave bus
);
  localparam int OCC_W  = $clog2(DEPTH) + 1;
  localparam int IDX_W  = $clog2(NUM_REQ);
  localparam int BCNT_W = $clog2(MAX_BURST + 1);

  localparam logic [OCC_W-1:0]  DEPTH_OCC = OCC_W'(DEPTH);
  localparam logic [OCC_W:0]    DEPTH_EXT = (OCC_W + 1)'(DEPTH);
  localparam logic [BCNT_W-1:0] BMAX      = BCNT_W'(MAX_BURST);

  typedef enum logic {IDLE, BURST} state_t;

  state_t                st;
  logic [IDX_W-1:0]      owner;
  logic [BCNT_W-1:0]     bcnt;
  logic [OCC_W-1:0]      occ;
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  rd_en;
  logic                  rd_valid;

  logic                  wcred;
  logic                  rcred;
  logic                  rd_ack;
  logic [OCC_W:0]        occ_sum;
  logic                  found;
  logic [IDX_W-1:0]      win;
  logic                  keep;
  logic                  grant_any;
  logic [IDX_W-1:0]      grant_idx;
  logic                  load_new;
  logic                  go_idle;
  logic [NUM_REQ-1:0]    gnt;

  // Credits count the strobe already in flight, so the lagging count never overshoots.
  assign occ_sum = {1'b0, occ} + {{OCC_W{1'b0}}, wr_en};
  assign wcred   = !bus.fifo_full && (occ_sum < DEPTH_EXT);
  assign rcred   = !bus.fifo_empty && (occ > {{(OCC_W-1){1'b0}}, rd_en});
  assign rd_ack  = !rst && bus.rd_req && rcred;

  // Round-robin search starting just after the current owner, wrapping back to it last.
  always_comb begin
    found = 1'b0;
    win   = owner;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!found && bus.req[(int'(owner) + k) % NUM_REQ]) begin
        found = 1'b1;
        win   = IDX_W'((int'(owner) + k) % NUM_REQ);
      end
    end
  end

  assign keep = (st == BURST) && bus.req[owner] && (bcnt < BMAX);

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    grant_any = 1'b0;
    grant_idx = owner;
    load_new  = 1'b0;
    go_idle   = 1'b0;
    if (!rst && wcred) begin
      if (keep) begin
        grant_any = 1'b1;
      end else if (found) begin
        grant_any = 1'b1;
        grant_idx = win;
        load_new  = 1'b1;
      end else begin
        go_idle   = 1'b1;
      end
    end
  end

  always_comb begin
    gnt = '0;
    if (grant_any) gnt[grant_idx] = 1'b1;
  end

  // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      st       <= IDLE;
      owner    <= IDX_W'(NUM_REQ - 1);
      bcnt     <= '0;
      occ      <= '0;
      wr_en    <= 1'b0;
      data_in  <= '0;
      rd_en    <= 1'b0;
      rd_valid <= 1'b0;
    end else begin
      if (wr_en && !rd_en && occ != DEPTH_OCC) begin
        occ <= occ + 1'b1;
      end else if (!wr_en && rd_en && occ != '0) begin
        occ <= occ - 1'b1;
      end

      wr_en <= grant_any;
      if (grant_any) data_in <= bus.req_data[grant_idx*DATA_WIDTH +: DATA_WIDTH];

      rd_en    <= rd_ack;
      rd_valid <= rd_en;

      if (load_new) begin
        owner <= grant_idx;
        bcnt  <= BCNT_W'(1);
        st    <= BURST;
      end else if (grant_any) begin
        bcnt  <= bcnt + 1'b1;
      end else if (go_idle) begin
        st    <= IDLE;
      end
    end
  end

  assign bus.gnt          = gnt;
  assign bus.rd_ack       = rd_ack;
  assign bus.fifo_wr_en   = wr_en;
  assign bus.fifo_data_in = data_in;
  assign bus.fifo_rd_en   = rd_en;
  assign bus.rd_valid     = rd_valid;
  assign bus.occupancy    = occ;
endmodule

// File: tb/tb_fifo_access_ctrl.sv
// Randomized and directed bench for fifo_access_ctrl with a behavioural FIFO, a rule-level
// arbitration/occupancy reference model and queue-based write/read data scoreboards.
module tb_fifo_access_ctrl;
  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int NREQ  = 4;
  localparam int MAXB  = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic chk_en = 1'b0;
  logic force_empty = 1'b0;

  always #5 clk = ~clk;

  fifo_access_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .NUM_REQ(NREQ)) bus ();

  fifo_access_ctrl #(
    .DATA_WIDTH(DW), .DEPTH(DEPTH), .NUM_REQ(NREQ), .MAX_BURST(MAXB)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
  endtask

  // Behavioural FIFO with flags registered after each edge.
  logic [DW-1:0] fq[$];
  logic          f_full  = 1'b0;
  logic          f_empty = 1'b1;
  logic [DW-1:0] fifo_dout = '0;

  assign bus.fifo_full  = f_full;
  assign bus.fifo_empty = f_empty | force_empty;

  always @(posedge clk) begin
    if (rst) begin
      fq.delete();
      f_full    <= 1'b0;
      f_empty   <= 1'b1;
      fifo_dout <= '0;
    end else begin
      if (bus.fifo_rd_en) begin
        check("fifo_underflow", 64'(fq.size() > 0), 64'd1);
        if (fq.size() > 0) fifo_dout <= fq.pop_front();
      end
      if (bus.fifo_wr_en) begin
        check("fifo_overflow", 64'(fq.size() < DEPTH), 64'd1);
        if (fq.size() < DEPTH) fq.push_back(bus.fifo_data_in);
      end
      f_full  <= (fq.size() == DEPTH);
      f_empty <= (fq.size() == 0);
    end
  end

  // Reference model: committed count, in-flight strobes and the round-robin/burst rules.
  int m_occ = 0, m_wr = 0, m_rd = 0, m_rdv = 0;
  int m_owner = NREQ - 1, m_cnt = 0;
  bit m_busy = 0;
  logic [DW-1:0] exp_wr[$];
  logic [DW-1:0] exp_rd[$];

  function automatic int next_req(input int from, input logic [NREQ-1:0] r);
    for (int k = 1; k <= NREQ; k++)
      if (r[(from + k) % NREQ]) return (from + k) % NREQ;
    return -1;
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      int eg, w;
      bit ea, wc, rc;
      logic [DW-1:0] wd;
      eg = -1;
      ea = 0;
      if (!rst) begin
        wc = !bus.fifo_full && (m_occ + m_wr) < DEPTH;
        rc = !bus.fifo_empty && m_occ > m_rd;
        ea = bus.rd_req && rc;
        if (wc) begin
          if (m_busy && bus.req[m_owner] && m_cnt < MAXB) begin
            eg = m_owner;
            m_cnt++;
          end else begin
            w = next_req(m_owner, bus.req);
            if (w >= 0) begin
              eg = w; m_owner = w; m_cnt = 1; m_busy = 1;
            end else begin
              m_busy = 0;
            end
          end
        end
      end
      check("gnt", 64'(bus.gnt), (eg >= 0) ? (64'd1 << eg) : 64'd0);
      check("rd_ack", 64'(bus.rd_ack), 64'(ea));
      check("occupancy", 64'(bus.occupancy), 64'(m_occ));
      check("fifo_wr_en", 64'(bus.fifo_wr_en), 64'(m_wr));
      check("fifo_rd_en", 64'(bus.fifo_rd_en), 64'(m_rd));
      check("rd_valid", 64'(bus.rd_valid), 64'(m_rdv));
      if (rst) begin
        m_occ = 0; m_wr = 0; m_rd = 0; m_rdv = 0;
        m_owner = NREQ - 1; m_cnt = 0; m_busy = 0;
        exp_wr.delete();
        exp_rd.delete();
      end else begin
        if (eg >= 0) begin
          wd = bus.req_data[eg*DW +: DW];
          exp_wr.push_back(wd);
          exp_rd.push_back(wd);
        end
        m_occ = m_occ + m_wr - m_rd;
        m_rdv = m_rd;
        m_wr  = (eg >= 0) ? 1 : 0;
        m_rd  = ea ? 1 : 0;
      end
    end
  end

  // Monitor: pops expected words whenever the DUT presents a write strobe or read data.
  always @(negedge clk) begin
    if (chk_en && !rst) begin
      if (bus.fifo_wr_en) begin
        if (exp_wr.size() == 0) check("wr_unexpected", 64'(bus.fifo_wr_en), 64'd0);
        else check("wr_data", 64'(bus.fifo_data_in), 64'(exp_wr.pop_front()));
      end
      if (bus.rd_valid) begin
        if (exp_rd.size() == 0) check("rd_unexpected", 64'(bus.rd_valid), 64'd0);
        else check("rd_data", 64'(fifo_dout), 64'(exp_rd.pop_front()));
      end
    end
  end

  task automatic step(input logic [NREQ-1:0] r, input logic rr, input logic fe);
    @(posedge clk);
    #1;
    bus.req      = r;
    bus.req_data = $urandom;
    bus.rd_req   = rr;
    force_empty  = fe;
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    #1 rst = 1'b1;
    bus.req = '0;
    bus.rd_req = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    bus.req      = '0;
    bus.req_data = '0;
    bus.rd_req   = 1'b0;
    @(posedge clk);
    #1 chk_en = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset priority: all requesters, fill to DEPTH, then no more grants.
    repeat (24) step(4'hF, 1'b0, 1'b0);
    // Drain: one read per cycle, then a read request with nothing left.
    repeat (20) step(4'h0, 1'b1, 1'b0);

    // Early release: requester 2 drops after two grants, requester 3 takes over.
    pulse_reset();
    step(4'b1100, 1'b0, 1'b0);
    step(4'b1100, 1'b0, 1'b0);
    repeat (4) step(4'b1000, 1'b0, 1'b0);

    // Steady state at full with one writer and a continuous reader.
    repeat (20) step(4'b0010, 1'b0, 1'b0);
    repeat (40) step(4'b0010, 1'b1, 1'b0);

    // Reset mid-burst with a write in flight.
    repeat (4) step(4'h0, 1'b1, 1'b0);
    step(4'hF, 1'b0, 1'b0);
    step(4'hF, 1'b0, 1'b0);
    pulse_reset();
    repeat (3) step(4'hF, 1'b0, 1'b0);

    // Spurious empty flag at occupancy 5.
    pulse_reset();
    repeat (5) step(4'b0001, 1'b0, 1'b0);
    repeat (3) step(4'h0, 1'b0, 1'b0);
    repeat (4) step(4'h0, 1'b1, 1'b1);
    repeat (4) step(4'h0, 1'b1, 1'b0);

    // Randomized mix of requests, reads and occasional spurious empty flags.
    for (int i = 0; i < 600; i++)
      step(NREQ'($urandom), 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 15) == 0));
    for (int i = 0; i < 200; i++)
      step(NREQ'($urandom), 1'($urandom_range(0, 3) == 0), 1'b0);

    repeat (6) step(4'h0, 1'b1, 1'b0);
    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/fifo_access_ctrl.md
# fifo_access_ctrl

Access controller that shares one `sync_fifo` instance between `NUM_REQ` write requesters and a single reader. Write-side arbitration is round-robin with a bounded burst length. The block is the only driver of the FIFO's `wr_en`, `rd_en` and `data_in`. It keeps its own occupancy count so that the FIFO's registered, lagging `full`/`empty` flags can never cause a lost or spurious transfer. It sits directly in front of the FIFO, and its FIFO-side outputs connect pin-for-pin to the FIFO.

## Interface
- `DATA_WIDTH`, 8, width of one data word.
- `DEPTH`, 16, number of FIFO entries; must match the attached FIFO.
- `NUM_REQ`, 4, number of write requesters (2..8).
- `MAX_BURST`, 4, maximum consecutive grants to one requester (≥1).

Ports:
- `clk` in 1: single clock; everything is on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req` in `NUM_REQ`: write request, one bit per requester.
- `req_data` in `NUM_REQ*DATA_WIDTH`: requester i's word is at bits `[i*DATA_WIDTH +: DATA_WIDTH]`.
- `gnt` out `NUM_REQ`: combinational, one-hot or zero; `gnt[i]` high means requester i's word is accepted this cycle.
- `fifo_wr_en` out 1: registered write strobe to the FIFO.
- `fifo_data_in` out `DATA_WIDTH`: registered write data to the FIFO.
- `fifo_full` in 1: FIFO full flag.
- `fifo_empty` in 1: FIFO empty flag.
- `rd_req` in 1: reader requests one word.
- `rd_ack` out 1: combinational; the read is accepted this cycle.
- `fifo_rd_en` out 1: registered read strobe to the FIFO.
- `rd_valid` out 1: registered; the FIFO's `data_out` holds the requested word during this cycle.
- `occupancy` out `$clog2(DEPTH)+1`: committed entry count.

## Operation
- **Occupancy (`occ`).**
  - +1 on every edge where `fifo_wr_en` is high.
  - −1 on every edge where `fifo_rd_en` is high.
  - If both are high on the same edge, `occ` is unchanged.
  - Range is 0..`DEPTH`. It never wraps.
- **Write credit.** `wcred` = `!fifo_full && (occ + fifo_wr_en) < DEPTH`. The write already in flight is counted.
- **Read credit.** `rcred` = `!fifo_empty && occ > fifo_rd_en`. The read already in flight is counted.
- **`rd_ack`.** `rd_ack` = `rd_req && rcred`.
- **Arbiter state.** Registers are `owner` (requester index), `bcnt` (0..`MAX_BURST`) and `st` ∈ {IDLE, BURST}.
- **IDLE.**
  - If `wcred` is high and any `req` is high, grant the first requester with `req` high, searching from `owner+1` upward with wrap-around.
  - Set `owner` to the winner, set `bcnt`=1, go to BURST.
- **BURST.**
  - If `req[owner]` is high, `bcnt < MAX_BURST` and `wcred` is high: grant `owner` and increment `bcnt`.
  - If `req[owner]` is low, or `bcnt == MAX_BURST`: this cycle behaves as an IDLE search from `owner+1`. If it finds a winner, load the new owner with `bcnt`=1 and stay in BURST. Otherwise go to IDLE.
  - If `wcred` is low: no grant; `owner`, `bcnt` and `st` hold.
  - With `MAX_BURST`=1 the arbiter is plain round-robin.
- **Write path.** On a grant to requester i:
  - next `fifo_wr_en` = 1;
  - next `fifo_data_in` = `req_data` slice i.
  - With no grant, `fifo_wr_en` = 0 and `fifo_data_in` holds its last value.
- **Read path.** Next `fifo_rd_en` = `rd_ack`. Next `rd_valid` = `fifo_rd_en`.
- **Reset.**
  - All outputs are 0: `gnt`, `rd_ack`, `fifo_wr_en`, `fifo_data_in`, `fifo_rd_en`, `rd_valid`, `occupancy`.
  - `st` = IDLE, `bcnt` = 0, `owner` = `NUM_REQ-1`, so requester 0 has top priority after reset.
  - A reset mid-burst or with a transfer in flight discards the in-flight strobes. The FIFO must be reset on the same `rst`.

## Timing
- **Write.** Grant in cycle t → `fifo_wr_en` and `fifo_data_in` valid in t+1 → the FIFO stores the word at the end of t+1, and `occ` increments at that same edge.
- **Read.** `rd_ack` in t → `fifo_rd_en` in t+1 → `rd_valid` in t+2, with data on the FIFO's `data_out`.
- **Throughput.** Sustained rate is one write and one read per cycle. A full FIFO still accepts a write in the same cycle a read frees a slot, one cycle after that read issues.
- **Simultaneous events.** Grant and `rd_ack` are independent and may occur in the same cycle.
- **Full boundary.** With `occ`=`DEPTH`-1 and a write in flight, no grant is issued.
- **Empty boundary.** With `occ`=1 and a read in flight, `rd_ack` is 0.
- **Flag lag.** `gnt` and `rd_ack` fall in the same cycle that `fifo_full` or `fifo_empty` rises, independent of `occ`.

## Test plan
- **Reset priority.** Reset, then all four `req` held high with `MAX_BURST`=4 and no reads → `gnt` order is 0,0,0,0,1,1,1,1,2… until `occ`=16. After that `gnt`=0 and `fifo_wr_en` stays 0.
- **Drain and refill.** From full, `rd_req` held for 16 cycles → `rd_valid` pulses 16 times, the data order matches write order, and `occ` reaches 0. The 17th `rd_req` gets `rd_ack`=0.
- **Early release.** Requester 2 alone drops `req` after 2 grants while `req[3]` is high → the next grant goes to 3 on the following cycle with `bcnt`=1, and no idle cycle appears.
- **Steady state at full.** At `occ`=16, `rd_req` and `req[1]` held high → one write per cycle following each read, and `occ` oscillates between 15 and 16, never 17.
- **Reset mid-burst.** Assert `rst` mid-burst with `fifo_wr_en`=1 → the next cycle has all outputs 0 and `occ`=0. The first grant after reset goes to requester 0.
- **Spurious flag.** Force `fifo_empty`=1 while `occ`=5 → `rd_ack`=0 for as long as `fifo_empty` is high. Reads resume the cycle it drops.
